atm_key_collector: RTL

//  Parametrised keyboard-entry collector for the crypto ATM. Arms on start for one input style, assembles

---
 rtl/atm_pkg.sv | 98 +++++++++
 rtl/atm_digit_buffer.sv | 88 ++++++++
 rtl/atm_key_collector.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/atm_pkg.sv
// Shared constants for the crypto ATM keyboard path: input styles, status
// codes, menu/currency encodings, ASCII key codes and small key classifiers.
package atm_pkg;

  // Input styles the ATM main FSM can request from the key collector.
  typedef enum logic [3:0] {
    STYLE_NONE      = 4'd0,
    SINGLE_KEY      = 4'd1,
    ACC_NUMBER      = 4'd2,
    PIN_NUMBER      = 4'd3,
    MENU_SELECTION  = 4'd4,
    CURRENCY_TYPE   = 4'd5,
    CURRENCY_AMOUNT = 4'd6
  } input_style_t;

  // Status codes reported alongside a finished entry.
  localparam logic [3:0] STATUS_NONE           = 4'b0000;
  localparam logic [3:0] STATUS_EXIT           = 4'b0111;
  localparam logic [3:0] STATUS_INPUT_COMPLETE = 4'b1000;
  localparam logic [3:0] STATUS_INPUT_TIMEOUT  = 4'b1001;

  // Main menu selections.
  typedef enum logic [1:0] {
    MENU_BALANCE  = 2'd0,
    MENU_CONVERT  = 2'd1,
    MENU_WITHDRAW = 2'd2,
    MENU_TRANSFER = 2'd3
  } menu_t;

  // Supported currencies.
  typedef enum logic [2:0] {
    CUR_USD = 3'd0,
    CUR_BTC = 3'd1,
    CUR_ETH = 3'd2,
    CUR_XRP = 3'd3,
    CUR_LTC = 3'd4
  } currency_t;

  // Collector FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } collector_state_t;

  // ASCII codes produced by the PS/2 decoder that carry meaning here.
  localparam logic [7:0] KEY_BACKSPACE = 8'h08;
  localparam logic [7:0] KEY_ENTER     = 8'h0D;
  localparam logic [7:0] KEY_CLEAR     = 8'h2A;  // '*'
  localparam logic [7:0] KEY_0         = 8'h30;
  localparam logic [7:0] KEY_1         = 8'h31;
  localparam logic [7:0] KEY_5         = 8'h35;
  localparam logic [7:0] KEY_9         = 8'h39;
  localparam logic [7:0] KEY_B         = 8'h62;
  localparam logic [7:0] KEY_C         = 8'h63;
  localparam logic [7:0] KEY_EXIT      = 8'h71;  // 'q'
  localparam logic [7:0] KEY_T         = 8'h74;
  localparam logic [7:0] KEY_W         = 8'h77;

  // True for the style codes the collector knows how to serve.
  function automatic logic style_is_defined(input logic [3:0] style);
    return (style >= 4'd1) && (style <= 4'd6);
  endfunction

  // Styles whose keystrokes build up a BCD digit field.
  function automatic logic style_takes_digits(input input_style_t style);
    return (style == ACC_NUMBER) || (style == PIN_NUMBER) ||
           (style == CURRENCY_AMOUNT);
  endfunction

  function automatic logic is_decimal_key(input logic [7:0] key);
    return (key >= KEY_0) && (key <= KEY_9);
  endfunction

  function automatic logic is_menu_key(input logic [7:0] key);
    return (key == KEY_B) || (key == KEY_C) || (key == KEY_W) || (key == KEY_T);
  endfunction

  // Maps b/c/w/t onto the menu encoding; only meaningful when is_menu_key.
  function automatic menu_t menu_of_key(input logic [7:0] key);
    menu_t sel;
    sel = MENU_BALANCE;
    if (key == KEY_C) sel = MENU_CONVERT;
    if (key == KEY_W) sel = MENU_WITHDRAW;
    if (key == KEY_T) sel = MENU_TRANSFER;
    return sel;
  endfunction

  function automatic logic is_currency_key(input logic [7:0] key);
    return (key >= KEY_1) && (key <= KEY_5);
  endfunction

  // '1'..'5' map to USD..LTC; the low three ASCII bits are 1..5.
  function automatic currency_t currency_of_key(input logic [7:0] key);
    return currency_t'(key[2:0] - 3'd1);
  endfunction

endpackage

// File: rtl/atm_digit_buffer.sv
// BCD digit shift register. A push shifts every nibble one place up and puts
// the new digit in [3:0]; a pop shifts everything back down, dropping the most
// recently typed digit. Pushing while full and popping while empty are ignored.
module atm_digit_buffer #(
  parameter int MAX_DIGITS = 8,
  parameter int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    push,
  input  logic                    pop,
  input  logic [3:0]              digit,
  output logic [4*MAX_DIGITS-1:0] value,
  output logic [CNT_W-1:0]        count,
  output logic                    full,
  output logic                    empty
);

  logic [4*MAX_DIGITS-1:0] value_reg;
  logic [4*MAX_DIGITS-1:0] value_next;
  logic [CNT_W-1:0]        count_reg;
  logic [CNT_W-1:0]        count_next;
  logic                    do_push;
  logic                    do_pop;

  assign full  = (count_reg == CNT_W'(MAX_DIGITS));
  assign empty = (count_reg == '0);

  // Clear dominates; push and pop are never requested together by the top,
  // but push wins if they ever are.
  assign do_push = push && !full && !clr;
  assign do_pop  = pop && !empty && !clr && !push;

  // Per-nibble next-value mux: each nibble takes its lower neighbour on push
  // and its upper neighbour on pop.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_DIGITS; gi++) begin : g_nibble
      logic [3:0] from_lower;
      logic [3:0] from_upper;

      if (gi == 0) begin : g_bottom
        assign from_lower = digit;
      end else begin : g_inner_lo
        assign from_lower = value_reg[4*(gi-1) +: 4];
      end

      if (gi == MAX_DIGITS - 1) begin : g_top
        assign from_upper = 4'd0;
      end else begin : g_inner_hi
        assign from_upper = value_reg[4*(gi+1) +: 4];
      end

      assign value_next[4*gi +: 4] = clr     ? 4'd0       :
                                     do_push ? from_lower :
                                     do_pop  ? from_upper :
                                               value_reg[4*gi +: 4];
    end
  endgenerate

  // Digit count follows the same clear/push/pop decisions as the nibbles.
  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (do_push) begin
      count_next = count_reg + CNT_W'(1);
    end else if (do_pop) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  // Register the digit field and its count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_reg <= '0;
      count_reg <= '0;
    end else begin
      value_reg <= value_next;
      count_reg <= count_next;
    end
  end

  assign value = value_reg;
  assign count = count_reg;

endmodule

// File: rtl/atm_key_collector.sv
// Keyboard-entry collector for the crypto ATM. Armed by the main FSM for one
// input style, it turns decoded ASCII keystrokes into a BCD digit field, a menu
// selection or a currency choice, and holds the result until acknowledged.
module atm_key_collector
  import atm_pkg::*;
#(
  parameter int  MAX_DIGITS  = 8,
  parameter int  MIN_DIGITS  = 4,
  parameter int  TIMEOUT_CYC = 50000000,
  localparam int CNT_W       = $clog2(MAX_DIGITS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [3:0]              input_style,
  input  logic                    key_valid,
  input  logic [7:0]              key_code,
  input  logic                    done_ack,
  output logic                    busy,
  output logic                    done,
  output logic [3:0]              status_code,
  output logic [4*MAX_DIGITS-1:0] value_bcd,
  output logic [CNT_W-1:0]        digit_count,
  output logic [1:0]              usr_input,
  output logic [2:0]              currency_type,
  output logic                    key_reject
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(TIMEOUT_CYC - 1);

  collector_state_t state_reg, state_next;
  input_style_t     style_reg, style_next;
  logic [3:0]       status_reg, status_next;
  menu_t            usr_input_reg, usr_input_next;
  currency_t        currency_reg, currency_next;
  logic             sel_valid_reg, sel_valid_next;
  logic [TMR_W-1:0] timer_reg, timer_next;
  logic             key_reject_reg, key_reject_next;

  logic             buf_clr;
  logic             buf_push;
  logic             buf_pop;
  logic             buf_full;
  logic             buf_empty;
  logic             enter_ok;

  atm_digit_buffer #(
    .MAX_DIGITS (MAX_DIGITS),
    .CNT_W      (CNT_W)
  ) u_digit_buffer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (buf_clr),
    .push  (buf_push),
    .pop   (buf_pop),
    .digit (key_code[3:0]),
    .value (value_bcd),
    .count (digit_count),
    .full  (buf_full),
    .empty (buf_empty)
  );

  // Decide whether Enter completes the entry for the latched style.
  always_comb begin
    enter_ok = 1'b0;
    case (style_reg)
      SINGLE_KEY:      enter_ok = 1'b1;
      ACC_NUMBER,
      PIN_NUMBER:      enter_ok = (digit_count >= CNT_W'(MIN_DIGITS));
      CURRENCY_AMOUNT: enter_ok = !buf_empty;
      MENU_SELECTION,
      CURRENCY_TYPE:   enter_ok = sel_valid_reg;
      default:         enter_ok = 1'b0;
    endcase
  end

  // Next-state, key classification and timer logic.
  always_comb begin
    state_next      = state_reg;
    style_next      = style_reg;
    status_next     = status_reg;
    usr_input_next  = usr_input_reg;
    currency_next   = currency_reg;
    sel_valid_next  = sel_valid_reg;
    timer_next      = timer_reg;
    key_reject_next = 1'b0;
    buf_clr         = 1'b0;
    buf_push        = 1'b0;
    buf_pop         = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        // Keys are ignored here; only a start with a known style arms us.
        if (start && style_is_defined(input_style)) begin
          state_next     = ST_COLLECT;
          style_next     = input_style_t'(input_style);
          status_next    = STATUS_NONE;
          sel_valid_next = 1'b0;
          timer_next     = '0;
          buf_clr        = 1'b1;
        end
      end

      ST_COLLECT: begin
        if (key_valid) begin
          // Any keystroke, accepted or not, counts as user activity.
          timer_next = '0;
          if (key_code == KEY_EXIT) begin
            status_next = STATUS_EXIT;
            state_next  = ST_DONE;
          end else if (key_code == KEY_ENTER) begin
            if (enter_ok) begin
              status_next = STATUS_INPUT_COMPLETE;
              state_next  = ST_DONE;
            end else begin
              key_reject_next = 1'b1;
            end
          end else if (style_takes_digits(style_reg) && is_decimal_key(key_code)) begin
            // A full field refuses further digits rather than wrapping.
            if (buf_full) begin
              key_reject_next = 1'b1;
            end else begin
              buf_push = 1'b1;
            end
          end else if (key_code == KEY_BACKSPACE) begin
            // Backspace on an empty field is silently a no-op.
            buf_pop = !buf_empty;
          end else if (key_code == KEY_CLEAR) begin
            buf_clr = 1'b1;
          end else if ((style_reg == MENU_SELECTION) && is_menu_key(key_code)) begin
            usr_input_next = menu_of_key(key_code);
            sel_valid_next = 1'b1;
          end else if ((style_reg == CURRENCY_TYPE) && is_currency_key(key_code)) begin
            currency_next  = currency_of_key(key_code);
            sel_valid_next = 1'b1;
          end else begin
            key_reject_next = 1'b1;
          end
        end else if (timer_reg == TIMER_LAST) begin
          status_next = STATUS_INPUT_TIMEOUT;
          state_next  = ST_DONE;
        end else begin
          timer_next = timer_reg + TMR_W'(1);
        end
      end

      ST_DONE: begin
        // Result is frozen; start is ignored even alongside done_ack.
        if (done_ack) begin
          state_next  = ST_IDLE;
          status_next = STATUS_NONE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and result registers; reset discards any partial entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      style_reg      <= STYLE_NONE;
      status_reg     <= STATUS_NONE;
      usr_input_reg  <= MENU_BALANCE;
      currency_reg   <= CUR_USD;
      sel_valid_reg  <= 1'b0;
      timer_reg      <= '0;
      key_reject_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      style_reg      <= style_next;
      status_reg     <= status_next;
      usr_input_reg  <= usr_input_next;
      currency_reg   <= currency_next;
      sel_valid_reg  <= sel_valid_next;
      timer_reg      <= timer_next;
      key_reject_reg <= key_reject_next;
    end
  end

  assign busy          = (state_reg == ST_COLLECT);
  assign done          = (state_reg == ST_DONE);
  assign status_code   = status_reg;
  assign usr_input     = usr_input_reg;
  assign currency_type = currency_reg;
  assign key_reject    = key_reject_reg;

endmodule
